// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder_arbiter block: FSM state encoding,
// default sizing constants and the requester-ID width helper.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Round-robin winner selection: scans the request vector starting at the
// pointer position, wrapping from NREQ-1 back to 0.
module rr_pick
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_j;

  // First requester at or after the pointer wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IDW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shared adder with round-robin arbitration among NREQ requesters.
// IDLE accepts one request, CALC registers the sum, RESP holds the result
// until the consumer takes it.
// Optional: define ADDER_ARBITER_OVF_EN to add the rsp_ovf signed-overflow output.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*WIDTH-1:0]         req_a,
  input  logic [NREQ*WIDTH-1:0]         req_b,
  output logic [NREQ-1:0]               req_ready,
  output logic                          rsp_valid,
  output logic [id_width(NREQ)-1:0]     rsp_id,
  output logic [WIDTH-1:0]              rsp_sum,
  output logic                          rsp_carry,
`ifdef ADDER_ARBITER_OVF_EN
  output logic                          rsp_ovf,
`endif
  input  logic                          rsp_ready
);

  localparam int IDW = id_width(NREQ);

  state_t           r_state, w_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_a, r_b;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_carry;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_a_arr [NREQ];
  logic [WIDTH-1:0] w_b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_accept  = (r_state == ST_IDLE) && w_any && !reset;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_carry = r_rsp_carry;

  // Next-state decode; req_ready only ever opens in IDLE outside reset.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          req_ready = w_grant;
          w_next    = ST_CALC;
        end
      end
      ST_CALC: w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, pointer, operand capture and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_carry <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= w_a_arr[w_idx];
        r_b   <= w_b_arr[w_idx];
        r_id  <= w_idx;
        r_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
      end
      if (r_state == ST_CALC) begin
        r_rsp_sum   <= w_sum[WIDTH-1:0];
        r_rsp_carry <= w_sum[WIDTH];
        r_rsp_id    <= r_id;
      end
    end
  end

`ifdef ADDER_ARBITER_OVF_EN
  logic r_rsp_ovf;
  assign rsp_ovf = r_rsp_ovf;

  // Signed overflow: operands agree in sign, sum sign differs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_ovf <= 1'b0;
    end else if (r_state == ST_CALC) begin
      r_rsp_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    end
  end
`endif

endmodule
